// File: rtl/sdr_port_arb.sv
// sdr_port_arb: round-robin read arbiter and ROM-download write path sharing one SDRAM port.
// Define SDR_ARB_TIMEOUT_EN to add a watchdog on the memory wait (sticky tmo_err).
module sdr_port_arb #(
  parameter int NCH = 4,
  parameter int AW  = 24,
  parameter int DW  = 16,
  parameter int TMO = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    cl_req,
  input  logic [NCH*AW-1:0] cl_addr,
  output logic [NCH*DW-1:0] cl_dout,
  output logic [NCH-1:0]    cl_rdy,
  input  logic              dl_mode,
  input  logic              wr_req,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_din,
  input  logic [DW/8-1:0]   wr_be,
  output logic              wr_rdy,
  output logic              port_req,
  output logic [AW-1:0]     port_addr,
  output logic [DW-1:0]     port_din,
  output logic [DW/8-1:0]   port_be,
  output logic              port_rnw,
  input  logic [DW-1:0]     port_dout,
  input  logic              port_rdy,
  output logic              busy,
  output logic              tmo_err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] pick;
  logic          pick_vld;
  logic          hold;
  logic          start_rd;
  logic          start_wr;
  logic          done;
  logic          tmo_hit;

  // Scan downwards so the requester closest to rr_ptr wins.
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NCH) j = j - NCH;
      if (cl_req[PW'(j)]) begin
        pick     = PW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  // A client still holds its request during its rdy pulse.
  assign hold = (|cl_rdy) | wr_rdy;
  assign busy = (state != IDLE);

  always_comb begin
    state_n  = state;
    start_rd = 1'b0;
    start_wr = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!hold) begin
          unique case (1'b1)
            dl_mode && wr_req: begin
              start_wr = 1'b1;
              state_n  = ISSUE;
            end
            !dl_mode && pick_vld: begin
              start_rd = 1'b1;
              state_n  = ISSUE;
            end
            default: ;
          endcase
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (port_rdy || tmo_hit) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      port_req  <= 1'b0;
      port_rnw  <= 1'b1;
      port_addr <= '0;
      port_din  <= '0;
      port_be   <= '0;
      cl_rdy    <= '0;
      wr_rdy    <= 1'b0;
      cl_dout   <= '0;
    end else begin
      state    <= state_n;
      port_req <= start_rd | start_wr;
      cl_rdy   <= '0;
      wr_rdy   <= 1'b0;
      if (start_wr) begin
        port_rnw  <= 1'b0;
        port_addr <= wr_addr;
        port_din  <= wr_din;
        port_be   <= wr_be;
      end
      if (start_rd) begin
        gnt       <= pick;
        port_rnw  <= 1'b1;
        port_addr <= cl_addr[pick*AW +: AW];
        port_din  <= '0;
        port_be   <= '1;
      end
      if (done) begin
        if (port_rnw) begin
          cl_rdy[gnt] <= 1'b1;
          if (port_rdy) cl_dout[gnt*DW +: DW] <= port_dout;
          rr_ptr <= (gnt == PW'(NCH - 1)) ? '0 : gnt + 1'b1;
        end else begin
          wr_rdy <= 1'b1;
        end
      end
    end
  end

`ifdef SDR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] wd_cnt;
  logic          tmo_q;

  // Expires after TMO cycles in WAIT; a late port_rdy still wins.
  assign tmo_hit = (state == WAIT) && !port_rdy
                && (wd_cnt == TW'(TMO - 1));
  assign tmo_err = tmo_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdr_port_arb.sv
// tb_sdr_port_arb: scoreboard bench for sdr_port_arb with a behavioural SDRAM port model.
// Completions are matched in order against expectations pushed when requests are driven.
module tb_sdr_port_arb;

  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    cl_req = '0;
  logic [NCH*AW-1:0] cl_addr = '0;
  logic [NCH*DW-1:0] cl_dout;
  logic [NCH-1:0]    cl_rdy;
  logic              dl_mode = 1'b0;
  logic              wr_req = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_din = '0;
  logic [DW/8-1:0]   wr_be = '0;
  logic              wr_rdy;
  logic              port_req;
  logic [AW-1:0]     port_addr;
  logic [DW-1:0]     port_din;
  logic [DW/8-1:0]   port_be;
  logic              port_rnw;
  logic [DW-1:0]     port_dout = '0;
  logic              rsp_rdy = 1'b0;
  logic              rdy_ovr = 1'b0;
  logic              busy;
  logic              tmo_err;

  sdr_port_arb #(.NCH(NCH), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clk      (clk),
    .reset    (reset),
    .cl_req   (cl_req),
    .cl_addr  (cl_addr),
    .cl_dout  (cl_dout),
    .cl_rdy   (cl_rdy),
    .dl_mode  (dl_mode),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_din   (wr_din),
    .wr_be    (wr_be),
    .wr_rdy   (wr_rdy),
    .port_req (port_req),
    .port_addr(port_addr),
    .port_din (port_din),
    .port_be  (port_be),
    .port_rnw (port_rnw),
    .port_dout(port_dout),
    .port_rdy (rsp_rdy | rdy_ovr),
    .busy     (busy),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    int            cl;
    logic [DW-1:0] data;
  } exp_t;

  typedef struct {
    logic            rnw;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   din;
    logic [DW/8-1:0] be;
  } acc_t;

  exp_t          exp_q[$];
  acc_t          acc_q[$];
  logic [DW-1:0] shadow[NCH];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            rsp_en = 1'b1;
  int            rsp_lat = 1;
  bit            force_en = 1'b0;
  logic [DW-1:0] force_d = '0;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  function automatic exp_t mk_rd(input int c, input logic [DW-1:0] d);
    exp_t e;
    e.wr = 1'b0; e.cl = c; e.data = d;
    return e;
  endfunction

  // Memory model: answers each port_req after rsp_lat cycles.
  always begin
    @(negedge clk);
    if (rsp_en && port_req === 1'b1) begin : rsp
      acc_t a;
      a.rnw  = port_rnw;
      a.addr = port_addr;
      a.din  = port_din;
      a.be   = port_be;
      acc_q.push_back(a);
      repeat (rsp_lat) @(posedge clk);
      #1;
      port_dout = force_en ? force_d : mem_rd(a.addr);
      rsp_rdy   = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (port_addr !== a.addr || port_rnw !== a.rnw || port_din !== a.din
          || port_be !== a.be || port_req !== 1'b0) begin
        n_err++;
        $display("FAIL port_stable addr=%h rnw=%b be=%b req=%b required addr=%h rnw=%b be=%b req=0",
                 port_addr, port_rnw, port_be, port_req, a.addr, a.rnw, a.be);
      end
      @(posedge clk);
      #1 rsp_rdy = 1'b0;
    end
  end

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && (cl_rdy !== '0 || wr_rdy !== 1'b0)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done cl_rdy=%b wr_rdy=%b required no completion", cl_rdy, wr_rdy);
      end else begin : pop
        exp_t          e;
        logic [NCH-1:0] want;
        logic [DW-1:0] got;
        e    = exp_q.pop_front();
        want = e.wr ? '0 : NCH'(1) << e.cl;
        got  = cl_dout[e.cl*DW +: DW];
        if (cl_rdy !== want || wr_rdy !== e.wr || (!e.wr && got !== e.data)) begin
          n_err++;
          $display("FAIL completion cl_rdy=%b wr_rdy=%b dout=%h required cl_rdy=%b wr_rdy=%b dout=%h",
                   cl_rdy, wr_rdy, got, want, e.wr, e.data);
        end
        if (!e.wr) shadow[e.cl] = e.data;
      end
    end
  end

  task automatic wait_q(input int left, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() <= left) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < NCH; i++) shadow[i] = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) shadow[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (port_req !== 1'b0 || port_rnw !== 1'b1 || port_addr !== '0
        || port_din !== '0 || port_be !== '0) begin
      n_err++;
      $display("FAIL reset_port req=%b rnw=%b addr=%h din=%h be=%b required 0 1 0 0 0",
               port_req, port_rnw, port_addr, port_din, port_be);
    end
    n_cmp++;
    if (cl_rdy !== '0 || wr_rdy !== 1'b0 || cl_dout !== '0) begin
      n_err++;
      $display("FAIL reset_client cl_rdy=%b wr_rdy=%b cl_dout=%h required all 0", cl_rdy, wr_rdy, cl_dout);
    end
    n_cmp++;
    if (busy !== 1'b0 || tmo_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status busy=%b tmo_err=%b required 0 0", busy, tmo_err);
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_single_read();
    bit ok;
    rsp_lat  = 1;
    force_en = 1'b1;
    force_d  = 16'hBEEF;
    exp_q.push_back(mk_rd(2, 16'hBEEF));
    @(posedge clk);
    #1;
    cl_addr[2*AW +: AW] = 24'h01_2345;
    cl_req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (port_req !== 1'b0) begin
      n_err++;
      $display("FAIL single_early port_req=%b required 0", port_req);
    end
    @(negedge clk);
    n_cmp++;
    if (port_req !== 1'b1 || busy !== 1'b1 || port_addr !== 24'h01_2345 || port_rnw !== 1'b1) begin
      n_err++;
      $display("FAIL single_issue req=%b busy=%b addr=%h rnw=%b required 1 1 012345 1",
               port_req, busy, port_addr, port_rnw);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cl_rdy !== 4'b0100) begin
      n_err++;
      $display("FAIL single_latency cl_rdy=%b required 0100", cl_rdy);
    end
    wait_q(0, 20, ok);
    cl_req   = '0;
    force_en = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_drain pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    bit            ok;
    bit            ord_ok;
    int            ord[5] = '{0, 1, 2, 3, 0};
    logic [AW-1:0] ad[NCH];
    int            base;
    pulse_reset();
    rsp_lat = 2;
    for (int i = 0; i < NCH; i++) begin
      ad[i] = AW'(24'h10_0000 + i * 24'h00_0111);
      cl_addr[i*AW +: AW] = ad[i];
    end
    for (int k = 0; k < 5; k++) exp_q.push_back(mk_rd(ord[k], mem_rd(ad[ord[k]])));
    base   = acc_q.size();
    cl_req = 4'b1111;
    wait_q(0, 100, ok);
    cl_req = '0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL rr_drain pending=%0d required 0", exp_q.size());
    end
    ord_ok = (acc_q.size() >= base + 5);
    for (int k = 0; k < 5 && ord_ok; k++)
      if (acc_q[base+k].addr !== ad[ord[k]] || acc_q[base+k].rnw !== 1'b1) ord_ok = 1'b0;
    n_cmp++;
    if (!ord_ok) begin
      n_err++;
      $display("FAIL rr_order accesses=%0d required 5 reads in order 0,1,2,3,0", acc_q.size() - base);
    end
    rsp_lat = 1;
  endtask

  task automatic test_dl_write();
    bit   ok;
    int   base;
    exp_t w;
    acc_t a;
    w.wr = 1'b1; w.cl = 0; w.data = '0;
    exp_q.push_back(w);
    exp_q.push_back(mk_rd(0, mem_rd(24'h00_0200)));
    base = acc_q.size();
    @(posedge clk);
    #1;
    dl_mode = 1'b1;
    wr_addr = 24'h00_0010;
    wr_din  = 16'hA55A;
    wr_be   = 2'b01;
    wr_req  = 1'b1;
    cl_addr[0 +: AW] = 24'h00_0200;
    cl_req  = 4'b0001;
    wait_q(1, 30, ok);
    wr_req = 1'b0;
    n_cmp++;
    if (!ok || acc_q.size() != base + 1) begin
      n_err++;
      $display("FAIL dl_write_done accesses=%0d required 1", acc_q.size() - base);
    end else begin
      a = acc_q[base];
      n_cmp++;
      if (a.rnw !== 1'b0 || a.addr !== 24'h00_0010 || a.din !== 16'hA55A || a.be !== 2'b01) begin
        n_err++;
        $display("FAIL dl_write_port rnw=%b addr=%h din=%h be=%b required 0 000010 a55a 01",
                 a.rnw, a.addr, a.din, a.be);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++;
    if (acc_q.size() != base + 1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL dl_blocks_read accesses=%0d busy=%b required 1 0", acc_q.size() - base, busy);
    end
    dl_mode = 1'b0;
    wait_q(0, 30, ok);
    cl_req = '0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL dl_client_after pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_ignore_wr();
    int   base;
    logic seen;
    base = acc_q.size();
    seen = 1'b0;
    @(posedge clk);
    #1;
    dl_mode = 1'b0;
    wr_addr = 24'h00_0044;
    wr_din  = 16'h1111;
    wr_be   = 2'b11;
    wr_req  = 1'b1;
    repeat (15) begin
      @(negedge clk);
      seen = seen | wr_rdy | busy;
    end
    wr_req = 1'b0;
    n_cmp++;
    if (seen !== 1'b0 || acc_q.size() != base) begin
      n_err++;
      $display("FAIL ignore_wr activity=%b accesses=%0d required 0 0", seen, acc_q.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    exp_q.push_back(mk_rd(3, mem_rd(24'h3C_3D3E)));
    exp_q.push_back(mk_rd(0, mem_rd(24'h0A_0B0C)));
    base = acc_q.size();
    @(posedge clk);
    #1;
    cl_addr[0 +: AW]    = 24'h0A_0B0C;
    cl_addr[3*AW +: AW] = 24'h3C_3D3E;
    cl_req = 4'b1001;
    wait_q(0, 60, ok);
    cl_req = '0;
    n_cmp++;
    if (!ok || acc_q.size() != base + 2 || acc_q[base].addr !== 24'h3C_3D3E) begin
      n_err++;
      $display("FAIL b2b_order ok=%b accesses=%0d required 2 starting with client 3", ok, acc_q.size() - base);
    end
    n_cmp++;
    if (cl_dout[2*DW +: DW] !== shadow[2]) begin
      n_err++;
      $display("FAIL dout_hold cl_dout2=%h required %h", cl_dout[2*DW +: DW], shadow[2]);
    end
  endtask

  task automatic test_reset_wait();
    bit   hit;
    logic seen;
    rsp_en = 1'b0;
    hit    = 1'b0;
    seen   = 1'b0;
    @(posedge clk);
    #1;
    cl_addr[1*AW +: AW] = 24'h05_5555;
    cl_req = 4'b0010;
    for (int i = 0; i < 10 && !hit; i++) begin
      @(negedge clk);
      hit = (port_req === 1'b1);
    end
    @(negedge clk);
    n_cmp++;
    if (!hit || busy !== 1'b1 || port_addr !== 24'h05_5555) begin
      n_err++;
      $display("FAIL rstwait_issue issued=%b busy=%b addr=%h required 1 1 055555", hit, busy, port_addr);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || port_rnw !== 1'b1 || port_addr !== '0 || port_req !== 1'b0
        || cl_dout !== '0 || cl_rdy !== '0 || tmo_err !== 1'b0) begin
      n_err++;
      $display("FAIL rstwait_async busy=%b rnw=%b addr=%h cl_dout=%h required 0 1 0 0",
               busy, port_rnw, port_addr, cl_dout);
    end
    for (int i = 0; i < NCH; i++) shadow[i] = '0;
    cl_req = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 rdy_ovr = 1'b1;
    @(posedge clk);
    #1 rdy_ovr = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | (|cl_rdy) | wr_rdy | busy;
    end
    n_cmp++;
    if (seen !== 1'b0 || cl_dout !== '0) begin
      n_err++;
      $display("FAIL rstwait_stray activity=%b cl_dout=%h required 0 0", seen, cl_dout);
    end
    rsp_en = 1'b1;
  endtask

  task automatic test_timeout();
    bit ok;
    int cnt;
    exp_q.push_back(mk_rd(0, mem_rd(24'h00_0777)));
    @(posedge clk);
    #1;
    cl_addr[0 +: AW] = 24'h00_0777;
    cl_req = 4'b0001;
    wait_q(0, 30, ok);
    cl_req = '0;
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL tmo_preload pending=%0d required 0", exp_q.size());
    end
    rsp_en = 1'b0;
    cnt    = 0;
`ifdef SDR_ARB_TIMEOUT_EN
    exp_q.push_back(mk_rd(0, shadow[0]));
    @(posedge clk);
    #1 cl_req = 4'b0001;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
      else if (cnt > 0) break;
    end
    cl_req = '0;
    n_cmp++;
    if (cnt != 1 + TMO || tmo_err !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_expire busy_cycles=%0d tmo_err=%b required %0d 1", cnt, tmo_err, 1 + TMO);
    end
    wait_q(0, 10, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL tmo_pulse pending=%0d required 0", exp_q.size());
    end
`else
    @(posedge clk);
    #1 cl_req = 4'b0001;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    cl_req = '0;
    n_cmp++;
    if (cnt < 38 || busy !== 1'b1 || tmo_err !== 1'b0) begin
      n_err++;
      $display("FAIL no_tmo busy_cycles=%0d busy=%b tmo_err=%b required >=38 1 0", cnt, busy, tmo_err);
    end
`endif
    pulse_reset();
    rsp_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (tmo_err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_clear tmo_err=%b busy=%b required 0 0", tmo_err, busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_dl_write();
    test_ignore_wr();
    test_back_to_back();
    test_reset_wait();
    test_timeout();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover pending=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdr_port_arb.md
SDR_PORT_ARB -- requirements
Module: sdr_port_arb

Interface
REQ-001 SHALL have parameter NCH, default 4: number of read clients sharing one SDRAM channel (1..8).
REQ-002 SHALL have parameter AW, default 24: 16-bit-word address width.
REQ-003 SHALL have parameter DW, default 16: data width; byte-enable width BW = DW/8.
REQ-004 SHALL have parameter TMO, default 255: watchdog limit in clk cycles (used only under REQ-030).
REQ-005 SHALL have ports clk in 1, system clock; reset in 1, asynchronous, active-high.
REQ-006 SHALL have port cl_req in NCH: per-client read request level, held until that client's cl_rdy.
REQ-007 SHALL have port cl_addr in NCH*AW: client i address in bits [i*AW +: AW], stable while cl_req[i].
REQ-008 SHALL have ports cl_dout out NCH*DW, per-client registered read data; cl_rdy out NCH, one-cycle completion pulse.
REQ-009 SHALL have ports dl_mode in 1, ROM download active; wr_req in 1; wr_addr in AW; wr_din in DW; wr_be in BW; wr_rdy out 1, one-cycle write-done pulse.
REQ-010 SHALL have ports port_req out 1, one-cycle pulse; port_addr out AW; port_din out DW; port_be out BW; port_rnw out 1; port_dout in DW; port_rdy in 1, one-cycle completion pulse.
REQ-011 SHALL have ports busy out 1, FSM not IDLE; tmo_err out 1, sticky watchdog flag.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, WAIT.
REQ-013 IDLE: if dl_mode=1 and wr_req=1, SHALL latch the write address, data, and byte enables, set port_rnw=0, and go to ISSUE.
REQ-014 IDLE: if dl_mode=0 and any cl_req is set, SHALL grant the first requesting client at or after rr_ptr (wrapping NCH-1 to 0), latch its address, set port_rnw=1, and go to ISSUE.
REQ-015 While dl_mode=1, SHALL never grant client reads; pending cl_req SHALL stay unacknowledged until dl_mode=0.
REQ-016 While dl_mode=0, SHALL ignore wr_req; wr_rdy SHALL stay 0.
REQ-017 ISSUE: SHALL assert port_req for exactly one cycle, then go to WAIT.
REQ-018 port_addr, port_din, port_be, and port_rnw SHALL remain stable from ISSUE until the cycle port_rdy is sampled.
REQ-019 WAIT: on port_rdy, a read SHALL load port_dout into the granted client's cl_dout and pulse that client's cl_rdy on the next cycle; a write SHALL pulse wr_rdy on the next cycle; the FSM SHALL return to IDLE.
REQ-020 Latency: request sampled in IDLE at cycle n gives port_req at n+1; port_rdy at cycle m gives cl_rdy/wr_rdy at m+1. Best case is 3 cycles request-to-rdy with 0-wait memory.
REQ-021 After a read completes for client g, rr_ptr SHALL become (g+1) mod NCH; writes SHALL not move rr_ptr.
REQ-022 A new grant SHALL NOT be made in the same cycle cl_rdy pulses; the next grant is evaluated in IDLE.
REQ-023 port_rdy outside WAIT SHALL be ignored.
REQ-024 A dl_mode change during ISSUE/WAIT SHALL NOT abort the access in flight.
REQ-025 cl_dout[i] SHALL hold its value until client i's next completion.
REQ-026 busy SHALL be 1 in ISSUE and WAIT.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, rr_ptr=0, port_req=0, port_rnw=1, port_addr/din/be=0, cl_rdy=0, wr_rdy=0, cl_dout=0, busy=0, tmo_err=0.
REQ-028 Reset during WAIT SHALL drop the access; a later port_rdy SHALL be ignored per REQ-023.
REQ-029 The first grant after reset release SHALL go to the lowest-index requester.

Configuration
REQ-030 With SDR_ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT. If it reaches TMO without port_rdy, the FSM SHALL go to IDLE, set tmo_err=1 (cleared only by reset), and pulse the granted cl_rdy/wr_rdy with the data unchanged.
REQ-031 Without SDR_ARB_TIMEOUT_EN: no counter; WAIT SHALL persist until port_rdy; tmo_err SHALL be constant 0.

Verification
REQ-032 NCH=4, cl_req=4'b1111 held, port_rdy 2 cycles after each port_req -> grant order 0,1,2,3,0; each cl_rdy is a single pulse.
REQ-033 Client 2 alone, addr 24'h01_2345, port_dout 16'hBEEF -> port_addr=24'h01_2345, port_rnw=1; cl_dout[2]=16'hBEEF with cl_rdy[2] one cycle after port_rdy.
REQ-034 dl_mode=1, wr_req with addr 24'h00_0010, din 16'hA55A, be 2'b01, while cl_req[0]=1 -> only the write is issued with port_rnw=0, be=2'b01, then wr_rdy; client 0 is served after dl_mode=0.
REQ-035 reset asserted mid-WAIT, then port_rdy -> all outputs at reset values; no cl_rdy/wr_rdy pulse.
REQ-036 With SDR_ARB_TIMEOUT_EN, TMO=8, port_rdy never returned -> return to IDLE 8 cycles into WAIT, tmo_err=1, cl_rdy pulsed; without the macro -> busy stays 1 indefinitely.
